// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry,
// common to the receiver, transmitter and baud divider.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both stages reset
// to the idle-high level so reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta and q a true two-stage shift;
  // blocking ones would collapse them into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// Oversampling 8N1 UART receiver clocked by clk and advanced by the divider's
// tick enable. Define UART_RX_PARITY_EN to add a parity bit and parity_err.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  uart_state_t          state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      // NOTE: the shift register is reset as well; it is a handful of flops,
      // not a RAM, and a defined value keeps rx_data traceable after reset.
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      // Strobes default low every clk so each lasts exactly one cycle,
      // regardless of tick spacing.
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (cnt == CNT_HALF) begin
              // Mid start bit: a line already back high was only a glitch.
              cnt     <= '0;
              bit_idx <= '0;
              state   <= rx_s ? IDLE : DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == CNT_LAST) begin
              cnt     <= '0;
              shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (cnt == CNT_LAST) begin
              cnt     <= '0;
              par_bad <= rx_s ^ (^shreg) ^ PARITY_ODD;
              state   <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (rx_s) begin
                // Returning to IDLE mid stop bit lets the next start edge
                // be caught immediately for back-to-back frames.
                state <= IDLE;
`ifdef UART_RX_PARITY_EN
                if (par_bad) begin
                  parity_err <= 1'b1;
                end else begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end
`else
                rx_data  <= shreg;
                rx_valid <= 1'b1;
`endif
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          BREAK: begin
            if (rx_s) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: a table of serial frames plus hand-written
// glitch and mid-frame reset sequences. Parity cases need UART_RX_PARITY_EN.
module tb_uart_rx_fsm;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par_bad;
    int         low_bits;
    int         idle_bits;
    int         period;
    logic       exp_busy_end;
    int         exp_valid;
    int         exp_ferr;
    int         exp_perr;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         n_perr = 0;
`endif

  int   tick_period = 1;
  int   tick_ph     = 0;
  int   n_checks    = 0;
  int   n_pass      = 0;
  int   n_valid     = 0;
  int   n_ferr      = 0;
  int   n_overlap   = 0;
  vec_t vecs[9];

  uart_rx_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  // Tick enable: one clk wide, every tick_period clks (1 = held high).
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_ph = (tick_ph + 1) % tick_period;
      tick    = (tick_ph == 0);
    end
  end

  // Pulse monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rx_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_ferr++;
    if (rx_valid === 1'b1 && frame_err === 1'b1) n_overlap++;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) n_perr++;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_clks(16 * tick_period);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int v0, f0;
`ifdef UART_RX_PARITY_EN
    int p0;
    p0 = n_perr;
`endif
    tick_period = v.period;
    v0 = n_valid;
    f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v.data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^v.data) ^ v.par_bad);
`endif
    rx_in = v.stop;
    wait_clks(8 * tick_period);
    check({tag, " busy_mid_stop"}, 32'(busy), 32'd1);
    wait_clks(8 * tick_period);
    check({tag, " busy_end_stop"}, 32'(busy), 32'(v.exp_busy_end));
    if (v.low_bits > 0) begin
      rx_in = 1'b0;
      wait_clks(v.low_bits * 16 * tick_period);
    end
    rx_in = 1'b1;
    wait_clks(v.idle_bits * 16 * tick_period);
    check({tag, " rx_valid_count"}, 32'(n_valid - v0), 32'(v.exp_valid));
    check({tag, " frame_err_count"}, 32'(n_ferr - f0), 32'(v.exp_ferr));
    check({tag, " rx_data"}, 32'(rx_data), 32'(v.exp_data));
`ifdef UART_RX_PARITY_EN
    check({tag, " parity_err_count"}, 32'(n_perr - p0), 32'(v.exp_perr));
`endif
  endtask

  initial begin
    int         v0, f0;
    logic [7:0] b77;

    //          data   stop  pbad low idle per busy_end val ferr perr exp_data
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 0, 1, 1, 1'b0, 1, 0, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 40, 2, 1, 1'b1, 0, 1, 0, 8'hA5};
    vecs[2] = '{8'h5A, 1'b1, 1'b0, 0, 1, 1, 1'b0, 1, 0, 0, 8'h5A};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 0, 0, 3, 1'b0, 1, 0, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 0, 0, 3, 1'b0, 1, 0, 0, 8'hFF};
    vecs[5] = '{8'h81, 1'b1, 1'b0, 0, 1, 3, 1'b0, 1, 0, 0, 8'h81};
    vecs[6] = '{8'h12, 1'b1, 1'b0, 0, 1, 1, 1'b0, 1, 0, 0, 8'h12};
    vecs[7] = '{8'h03, 1'b1, 1'b0, 0, 1, 1, 1'b0, 1, 0, 0, 8'h03};
    vecs[8] = '{8'h03, 1'b1, 1'b1, 0, 1, 1, 1'b0, 0, 0, 1, 8'h03};

    rst   = 1'b1;
    rx_in = 1'b1;
    wait_clks(3);
    check("reset rx_data", 32'(rx_data), 32'h0);
    check("reset rx_valid", 32'(rx_valid), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    rst = 1'b0;
    wait_clks(4);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start glitch: low for 4 ticks only, rejected at the mid-start sample.
    tick_period = 1;
    v0 = n_valid;
    f0 = n_ferr;
    rx_in = 1'b0;
    wait_clks(4);
    rx_in = 1'b1;
    wait_clks(2);
    check("glitch busy_high", 32'(busy), 32'd1);
    wait_clks(14);
    check("glitch busy_low", 32'(busy), 32'd0);
    check("glitch rx_valid_count", 32'(n_valid - v0), 32'd0);
    check("glitch frame_err_count", 32'(n_ferr - f0), 32'd0);
    check("glitch rx_data", 32'(rx_data), 32'h81);

    // Reset during data bit 4 of 0x77.
    b77 = 8'h77;
    v0 = n_valid;
    f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b77[i]);
    rx_in = b77[4];
    wait_clks(8);
    check("midframe busy", 32'(busy), 32'd1);
    rst   = 1'b1;
    rx_in = 1'b1;
    wait_clks(1);
    check("midreset rx_data", 32'(rx_data), 32'h0);
    check("midreset rx_valid", 32'(rx_valid), 32'h0);
    check("midreset frame_err", 32'(frame_err), 32'h0);
    check("midreset busy", 32'(busy), 32'h0);
    rst = 1'b0;
    wait_clks(48);
    check("midreset rx_valid_count", 32'(n_valid - v0), 32'd0);
    check("midreset frame_err_count", 32'(n_ferr - f0), 32'd0);
    run_vec(vecs[6], "after_reset");

`ifdef UART_RX_PARITY_EN
    run_vec(vecs[7], "parity_good");
    run_vec(vecs[8], "parity_bad");
`endif

    check("valid_and_frame_err_overlap", 32'(n_overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
